calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Sequences one BCD arithmetic operation at a time. Two 4-digit BCD
//   operands are captured on start and converted to binary, one digit per
//   operand per cycle. Add and subtract each take one execute cycle.
//   Multiply is a 16-step shift-add. Every result is reported with a
//   one-cycle done pulse.
//
// Parameters
//   SAT     1: an overflowing product saturates to 16'hFFFF
//           0: an overflowing product keeps its low 16 bits
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous reset, active low
//   start   begin an operation (sampled only while idle)
//   op      00 add, 01 subtract (A-B), 10 multiply, 11 reserved
//   A1..A4  operand A BCD digits, A1 thousands .. A4 units
//   B1..B4  operand B BCD digits, B1 thousands .. B4 units
//   busy    high from the cycle after start is accepted through the done cycle
//   done    one-cycle pulse, result fields valid
//   result  unsigned magnitude of the outcome
//   neg     subtract produced a negative outcome
//   ovf     multiply product exceeded 65535
//   err     invalid BCD digit or reserved op
module calc_sequencer #(
  parameter bit SAT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  A1,
  input  logic [3:0]  A2,
  input  logic [3:0]  A3,
  input  logic [3:0]  A4,
  input  logic [3:0]  B1,
  input  logic [3:0]  B2,
  input  logic [3:0]  B3,
  input  logic [3:0]  B4,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        neg,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] a_dig;       // captured digits, next digit to consume in [15:12]
  logic [15:0] b_dig;
  logic        bad_q;       // captured digits or op unusable
  logic [13:0] acc_a;
  logic [13:0] acc_b;
  logic [3:0]  cnt;
  logic [26:0] prod;        // 9999*9999 < 2^27
  logic [26:0] mcand;
  logic [13:0] mplier;

  logic [13:0] acc_a_nx;
  logic [13:0] acc_b_nx;
  logic [26:0] prod_nx;

  function automatic logic bcd_bad(input logic [15:0] d);
    return (d[15:12] > 4'd9) || (d[11:8] > 4'd9) ||
           (d[7:4]   > 4'd9) || (d[3:0]  > 4'd9);
  endfunction

  function automatic logic [15:0] sat_prod(input logic [26:0] p);
    if (p > 27'd65535)
      return SAT ? 16'hFFFF : p[15:0];
    return p[15:0];
  endfunction

  always_comb begin
    acc_a_nx = acc_a * 14'd10 + {10'd0, a_dig[15:12]};
    acc_b_nx = acc_b * 14'd10 + {10'd0, b_dig[15:12]};
    prod_nx  = prod + (mplier[0] ? mcand : 27'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      a_dig  <= '0;
      b_dig  <= '0;
      bad_q  <= 1'b0;
      acc_a  <= '0;
      acc_b  <= '0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_dig <= {A1, A2, A3, A4};
            b_dig <= {B1, B2, B3, B4};
            bad_q <= bcd_bad({A1, A2, A3, A4}) || bcd_bad({B1, B2, B3, B4}) ||
                     (op == OP_RSV);
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          acc_a <= acc_a_nx;
          acc_b <= acc_b_nx;
          a_dig <= {a_dig[11:0], 4'd0};
          b_dig <= {b_dig[11:0], 4'd0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd3) begin
            cnt <= '0;
            if (bad_q) begin
              result <= '0;
              neg    <= 1'b0;
              ovf    <= 1'b0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              // Multiplier operands are seeded from the final accumulator
              // values so that all 16 shift-add steps land in EXEC.
              prod   <= '0;
              mcand  <= {13'd0, acc_a_nx};
              mplier <= acc_b_nx;
              state  <= EXEC;
            end
          end
        end

        EXEC: begin
          case (op_q)
            OP_ADD: begin
              result <= {1'b0, {1'b0, acc_a} + {1'b0, acc_b}};
              neg    <= 1'b0;
              ovf    <= 1'b0;
              err    <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
            OP_SUB: begin
              if (acc_a >= acc_b) begin
                result <= {2'b00, acc_a - acc_b};
                neg    <= 1'b0;
              end else begin
                result <= {2'b00, acc_b - acc_a};
                neg    <= 1'b1;
              end
              ovf   <= 1'b0;
              err   <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
            OP_MUL: begin
              prod   <= prod_nx;
              mcand  <= {mcand[25:0], 1'b0};
              mplier <= {1'b0, mplier[13:1]};
              cnt    <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                result <= sat_prod(prod_nx);
                ovf    <= (prod_nx > 27'd65535);
                neg    <= 1'b0;
                err    <= 1'b0;
                done   <= 1'b1;
                state  <= DONE;
              end
            end
            default: begin
              // Reserved op is trapped in LOAD; recover defensively.
              result <= '0;
              neg    <= 1'b0;
              ovf    <= 1'b0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end
          endcase
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Directed bench for calc_sequencer (SAT=1). Each operation is applied
//   with a start pulse. Latency, in edges after the accepting edge, and the
//   result fields are compared against hand-computed values.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  A1 = 4'd0, A2 = 4'd0, A3 = 4'd0, A4 = 4'd0;
  logic [3:0]  B1 = 4'd0, B2 = 4'd0, B3 = 4'd0, B4 = 4'd0;
  logic        busy, done, neg, ovf, err;
  logic [15:0] result;

  int n_chk  = 0;
  int n_pass = 0;

  calc_sequencer #(.SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .busy(busy), .done(done), .result(result),
    .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_in(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o;
    {A1, A2, A3, A4} = a;
    {B1, B2, B3, B4} = b;
  endtask

  // Called just after the accepting edge; returns edges until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 60);
  endtask

  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] er,
                        input logic en, input logic eo, input logic ee);
    int n;
    @(negedge clk);
    set_in(o, a, b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "/busy"}, busy, 1);
    wait_done(n);
    check({name, "/latency"}, n, lat);
    check({name, "/result"}, result, er);
    check({name, "/neg"}, neg, en);
    check({name, "/ovf"}, ovf, eo);
    check({name, "/err"}, err, ee);
    check({name, "/busy_done"}, busy, 1);
    @(posedge clk); #1;
    check({name, "/done_pulse"}, done, 0);
    check({name, "/idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int dones;
    int done_at;

    // Reset state
    #12;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/result", result, 0);
    check("rst/flags", {neg, ovf, err}, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("add", 2'b00, 16'h1234, 16'h0766, 5, 16'd2000, 0, 0, 0);

    // Re-pulsed start during LOAD and EXEC and changed operands mid-flight
    @(negedge clk);
    set_in(2'b00, 16'h0100, 16'h0023);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_in(2'b10, 16'h9999, 16'h9999);
    dones = 0;
    done_at = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        done_at = i;
        check("repulse/result", result, 16'd123);
      end
      if (i == 2) check("repulse/stable", result, 16'd2000);
      start = (i == 2 || i == 4);
    end
    check("repulse/dones", dones, 1);
    check("repulse/latency", done_at, 5);
    check("repulse/no_queue", busy, 0);

    run_op("sub_neg", 2'b01, 16'h0012, 16'h0100, 5, 16'd88, 1, 0, 0);
    run_op("sub_zero", 2'b01, 16'h5555, 16'h5555, 5, 16'd0, 0, 0, 0);
    run_op("mul_max", 2'b10, 16'h0255, 16'h0257, 20, 16'd65535, 0, 0, 0);

    // Reset during multiply EXEC
    @(negedge clk);
    set_in(2'b10, 16'h9999, 16'h9999);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    check("midrst/busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst/busy", busy, 0);
    check("midrst/result", result, 0);
    check("midrst/flags", {done, neg, ovf, err}, 0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst/no_done", dones, 0);

    run_op("post_rst_add", 2'b00, 16'h0001, 16'h0002, 5, 16'd3, 0, 0, 0);
    run_op("mul_ovf", 2'b10, 16'h9999, 16'h9999, 20, 16'hFFFF, 0, 1, 0);
    run_op("bad_digit", 2'b00, 16'h12A4, 16'h0001, 4, 16'd0, 0, 0, 1);
    run_op("bad_op", 2'b11, 16'h0001, 16'h0002, 4, 16'd0, 0, 0, 1);

    // Back-to-back with start held high
    @(negedge clk);
    set_in(2'b00, 16'h0004, 16'h0005);
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    check("b2b/latency1", n, 5);
    check("b2b/result1", result, 16'd9);
    @(posedge clk); #1;
    check("b2b/idle_gap", busy, 0);
    @(posedge clk); #1;
    check("b2b/reaccept", busy, 1);
    start = 1'b0;
    wait_done(n);
    check("b2b/latency2", n, 5);
    check("b2b/result2", result, 16'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
